// File: rtl/mux_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl_pkg
// Shared constants for the 16:1 mux scan sequencer: default channel count,
// select width, default settle delay, settle-counter width and the legacy
// state encodings used by mux_scan_ctrl.
// No ports (package).
// -----------------------------------------------------------------------------
package mux_scan_ctrl_pkg;

    localparam int unsigned MUX_N          = 16;
    localparam int unsigned MUX_SEL_W      = 4;
    localparam int unsigned MUX_SETTLE_DEF = 1;

    // Settle counter width; bounds SETTLE to 0..15.
    localparam int unsigned MUX_CNT_W      = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

endpackage

// File: rtl/mux_settle_cnt.sv
// -----------------------------------------------------------------------------
// mux_settle_cnt
// Loadable down-counter that times the settle interval of one channel step.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (value -> 0)
//   clr       synchronous clear to 0 (highest priority after reset)
//   load      load load_val
//   load_val  value loaded on load
//   dec       decrement by one; saturates at 0
//   zero      high while the counter value is 0
// -----------------------------------------------------------------------------
module mux_settle_cnt
    import mux_scan_ctrl_pkg::*;
#(
    parameter int unsigned W = MUX_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Sequencer for the 16:1 channel mux. Steps sel through 0..N-1, waits SETTLE
// cycles after each select change, samples y_in, and publishes the assembled
// word on data_out with a one-cycle valid pulse.
//
// Optional feature: define MUX_SCAN_CONT_EN to add the cont input. With
// cont=1 at the final-sample edge the block publishes the word and restarts
// a new scan at once without leaving SCAN.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request one scan (only honoured in IDLE)
//   abort     synchronous cancel of a running scan; beats start
//   cont      (MUX_SCAN_CONT_EN only) continuous re-scan request
//   y_in      mux output for the current sel
//   sel       registered mux select
//   busy      high while a scan is running
//   data_out  last completed scan word; bit k sampled with sel=k
//   valid     one-cycle pulse when data_out updates
// -----------------------------------------------------------------------------
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int unsigned N      = MUX_N,
    parameter int unsigned SEL_W  = MUX_SEL_W,
    parameter int unsigned SETTLE = MUX_SETTLE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
`ifdef MUX_SCAN_CONT_EN
    input  logic             cont,
`endif
    input  logic             y_in,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic [N-1:0]     data_out,
    output logic             valid
);

    localparam logic [MUX_CNT_W-1:0] SETTLE_V = MUX_CNT_W'(SETTLE);
    localparam logic [SEL_W-1:0]     LAST_SEL = SEL_W'(N - 1);

    logic [0:0]   state;
    // Samples of channels 0..N-2; the last channel goes straight to data_out.
    logic [N-2:0] shadow;

    logic cont_i;
    logic scanning;
    logic last_ch;
    logic accept;
    logic do_abort;
    logic sample;
    logic finish;
    logic restart;
    logic cnt_zero;
    logic cnt_load;
    logic cnt_dec;

`ifdef MUX_SCAN_CONT_EN
    assign cont_i = cont;
`else
    assign cont_i = 1'b0;
`endif

    assign scanning = (state == ST_SCAN);
    assign last_ch  = (sel == LAST_SEL);
    assign accept   = !scanning && start && !abort;
    assign do_abort = scanning && abort;
    assign sample   = scanning && !abort && cnt_zero;
    assign finish   = sample && last_ch;
    assign restart  = finish && cont_i;

    // Reload the settle interval on every select change: scan start,
    // channel advance and continuous restart.
    assign cnt_load = accept || (sample && !last_ch) || restart;
    assign cnt_dec  = scanning && !abort && !cnt_zero;

    mux_settle_cnt #(
        .W (MUX_CNT_W)
    ) u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (do_abort),
        .load     (cnt_load),
        .load_val (SETTLE_V),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sel      <= '0;
            shadow   <= '0;
            data_out <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= finish;
            if (do_abort) begin
                state  <= ST_IDLE;
                sel    <= '0;
                shadow <= '0;
            end else if (accept) begin
                state <= ST_SCAN;
                sel   <= '0;
            end else if (sample) begin
                if (last_ch) begin
                    data_out <= {y_in, shadow};
                    sel      <= '0;
                    state    <= restart ? ST_SCAN : ST_IDLE;
                end else begin
                    shadow[sel] <= y_in;
                    sel         <= sel + 1'b1;
                end
            end
        end
    end

    assign busy = scanning;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Two sequencers (SETTLE=1 and SETTLE=0) share clock, start/abort/cont and a
// behavioural 16:1 mux driven from mux_in. A timing-rule reference model
// predicts each completed scan; a monitor compares DUT outputs every cycle
// and pops expected words from per-instance scoreboards on valid.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

    localparam int N = 16;
`ifdef MUX_SCAN_CONT_EN
    localparam bit CONT_ON = 1'b1;
`else
    localparam bit CONT_ON = 1'b0;
`endif

    typedef struct {
        int          e;
        logic [15:0] d;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        cont  = 1'b0;
    logic [15:0] mux_in = '0;

    logic [3:0]  sel0, sel1;
    logic        busy0, busy1, valid0, valid1;
    logic [15:0] d0, d1;
    logic        y0, y1;

    assign y0 = mux_in[sel0];
    assign y1 = mux_in[sel1];

    mux_scan_ctrl #(.N(16), .SEL_W(4), .SETTLE(1)) dut_s1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
`ifdef MUX_SCAN_CONT_EN
        .cont     (cont),
`endif
        .y_in     (y0),
        .sel      (sel0),
        .busy     (busy0),
        .data_out (d0),
        .valid    (valid0)
    );

    mux_scan_ctrl #(.N(16), .SEL_W(4), .SETTLE(0)) dut_s0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
`ifdef MUX_SCAN_CONT_EN
        .cont     (cont),
`endif
        .y_in     (y1),
        .sel      (sel1),
        .busy     (busy1),
        .data_out (d1),
        .valid    (valid1)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model state, per instance: scan running, start edge, end edge.
    bit          act  [2];
    int          t0   [2];
    int          ende [2];
    logic [15:0] last [2];
    logic [15:0] hist [int];
    exp_t        q0[$];
    exp_t        q1[$];

    int nvec  = 0;
    int nfail = 0;

    function automatic int period(input int i);
        return (i == 0) ? 2 : 1;   // SETTLE+1
    endfunction

    task automatic cmp(input string name, input int i, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s inst%0d edge %0d: got %0h expected %0h",
                     name, i, edge_cnt, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and advance the model
    // for the rising edge E that will sample them.
    task automatic step(input logic st, input logic ab, input logic c,
                        input logic [15:0] din);
        int E;
        @(negedge clk);
        start  = st;
        abort  = ab;
        cont   = c;
        mux_in = din;
        E = edge_cnt + 1;
        hist[E] = din;
        for (int i = 0; i < 2; i++) begin
            int sp;
            sp = period(i);
            if (act[i]) begin
                if (ab) begin
                    act[i] = 1'b0;
                end else if (E == ende[i]) begin
                    logic [15:0] w;
                    exp_t x;
                    for (int k = 0; k < N; k++) begin
                        logic [15:0] h;
                        h = hist[t0[i] + (k + 1) * sp];
                        w[k] = h[k];
                    end
                    x.e = E;
                    x.d = w;
                    if (i == 0) q0.push_back(x); else q1.push_back(x);
                    last[i] = w;
                    if (CONT_ON && c) begin
                        t0[i]   = E;
                        ende[i] = E + N * sp;
                    end else begin
                        act[i] = 1'b0;
                    end
                end
            end else if (st && !ab) begin
                act[i]  = 1'b1;
                t0[i]   = E;
                ende[i] = E + N * sp;
            end
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            act[i]  = 1'b0;
            last[i] = '0;
        end
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk(input int i, input logic v, input logic b,
                       input logic [3:0] s, input logic [15:0] d);
        int   E;
        bit   have;
        exp_t x;
        E = edge_cnt;
        cmp("busy", i, {31'b0, b}, {31'b0, act[i]});
        cmp("sel", i, {28'b0, s},
            act[i] ? 32'((E - t0[i]) / period(i)) : 32'd0);
        cmp("data_out", i, {16'b0, d}, {16'b0, last[i]});
        if (i == 0) have = (q0.size() > 0) && (q0[0].e == E);
        else        have = (q1.size() > 0) && (q1[0].e == E);
        cmp("valid", i, {31'b0, v}, {31'b0, have});
        if (have) begin
            if (i == 0) x = q0.pop_front(); else x = q1.pop_front();
            cmp("scan_word", i, {16'b0, d}, {16'b0, x.d});
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk(0, valid0, busy0, sel0, d0);
            chk(1, valid1, busy1, sel1, d1);
        end
    end

    initial begin
        logic        st, ab, c;
        logic [15:0] din;

        do_reset(3);
        repeat (20) step(0, 0, 0, 16'h0000);

        // Single scan with a stray start while busy, then back-to-back
        // start in the valid cycle of the SETTLE=1 instance.
        step(1, 0, 0, 16'hA5C3);
        repeat (4) step(0, 0, 0, 16'hA5C3);
        step(1, 0, 0, 16'hA5C3);
        repeat (27) step(0, 0, 0, 16'hA5C3);
        step(1, 0, 0, 16'h1234);
        repeat (40) step(0, 0, 0, 16'h1234);

        step(1, 0, 0, 16'h8001);
        repeat (40) step(0, 0, 0, 16'h8001);

        step(1, 0, 0, 16'hA5C3);
        repeat (40) step(0, 0, 0, 16'hA5C3);

        // Abort at T0+10 discards the FFFF scan.
        step(1, 0, 0, 16'hFFFF);
        repeat (9) step(0, 0, 0, 16'hFFFF);
        step(0, 1, 0, 16'hFFFF);
        repeat (10) step(0, 0, 0, 16'hFFFF);

        // abort and start together in IDLE: no scan.
        step(1, 1, 0, 16'hFFFF);
        repeat (5) step(0, 0, 0, 16'hFFFF);

        // Reset mid-scan.
        step(1, 0, 0, 16'h3C3C);
        repeat (12) step(0, 0, 0, 16'h3C3C);
        do_reset(2);
        repeat (5) step(0, 0, 0, 16'h3C3C);

`ifdef MUX_SCAN_CONT_EN
        step(1, 0, 1, 16'h0F0F);
        repeat (100) step(0, 0, 1, 16'h0F0F);
        repeat (40) step(0, 0, 0, 16'h0F0F);
`endif

        repeat (2000) begin
            st  = ($urandom_range(0, 7) == 0);
            ab  = ($urandom_range(0, 63) == 0);
            c   = ($urandom_range(0, 3) != 0);
            din = 16'($urandom);
            step(st, ab, c, din);
        end
        repeat (40) step(0, 0, 0, 16'h0000);

        cmp("pending", 0, 32'(q0.size() + q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
